// File: rtl/dart_match.sv
// Two-player dart match controller: alternating A/B throws over a valid/ready handshake,
// per-round comparison, saturating totals and a match winner. Optional DART_BULLSEYE_BONUS_EN.
module dart_match #(
  parameter int COORD_W = 2,
  parameter int ROUNDS  = 5,
  parameter int SCORE_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         throw_valid,
  input  logic [COORD_W-1:0]           throw_x,
  input  logic [COORD_W-1:0]           throw_y,
  output logic                         throw_ready,
  output logic                         turn,
  output logic [COORD_W:0]             last_points,
  output logic [$clog2(ROUNDS+1)-1:0]  round_cnt,
  output logic [SCORE_W-1:0]           score_a,
  output logic [SCORE_W-1:0]           score_b,
  output logic [$clog2(ROUNDS+1)-1:0]  wins_a,
  output logic [$clog2(ROUNDS+1)-1:0]  wins_b,
  output logic                         round_valid,
  output logic [1:0]                   round_result,
  output logic                         done,
  output logic [1:0]                   winner
);

  localparam int CNT_W = $clog2(ROUNDS+1);
  localparam int PW    = COORD_W + 1;
  localparam int SUM_W = ((SCORE_W > PW) ? SCORE_W : PW) + 1;
  localparam int PMAX  = (1 << COORD_W) - 1;

  // Handshake: a throw transfers on a rising edge where throw_valid and throw_ready are
  // both high; throw_ready depends only on state, never on throw_valid.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_A = 3'd1,
    S_WAIT_B = 3'd2,
    S_EVAL   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]      pa, pb;
  logic [PW-1:0]      points;
  logic [COORD_W-1:0] coord_max;
  logic               accept;
  logic [CNT_W-1:0]   round_cnt_inc;
  logic [CNT_W-1:0]   wins_a_nxt, wins_b_nxt;
  logic [1:0]         winner_nxt;
  logic               last_round;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [PW-1:0]      p);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] smax;
    sum  = SUM_W'(s) + SUM_W'(p);
    smax = SUM_W'({SCORE_W{1'b1}});
    if (sum > smax) return {SCORE_W{1'b1}};
    return sum[SCORE_W-1:0];
  endfunction

  always_comb begin
    coord_max = (throw_x > throw_y) ? throw_x : throw_y;
    points    = PW'(PMAX) - PW'(coord_max);
`ifdef DART_BULLSEYE_BONUS_EN
    if (coord_max == '0) points = PW'(2 * PMAX);
`endif
  end

  assign accept        = throw_valid & throw_ready;
  assign round_cnt_inc = round_cnt + CNT_W'(1);
  assign last_round    = (round_cnt_inc == CNT_W'(ROUNDS));
  assign done          = (state == S_DONE);

  always_comb begin
    state_nxt    = state;
    throw_ready  = 1'b0;
    turn         = 1'b0;
    round_valid  = 1'b0;
    round_result = 2'b00;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_WAIT_A;
      end
      S_WAIT_A: begin
        throw_ready = 1'b1;
        if (accept) state_nxt = S_WAIT_B;
      end
      S_WAIT_B: begin
        throw_ready = 1'b1;
        turn        = 1'b1;
        if (accept) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        round_valid = 1'b1;
        if (pa > pb)      round_result = 2'b01;
        else if (pb > pa) round_result = 2'b10;
        else              round_result = 2'b11;
        state_nxt = last_round ? S_DONE : S_WAIT_A;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Winner is decided from the wins as they will be after this EVAL; scores are stable here.
  always_comb begin
    wins_a_nxt = wins_a + CNT_W'(round_result == 2'b01);
    wins_b_nxt = wins_b + CNT_W'(round_result == 2'b10);
    if (wins_a_nxt > wins_b_nxt)      winner_nxt = 2'b01;
    else if (wins_b_nxt > wins_a_nxt) winner_nxt = 2'b10;
    else if (score_a > score_b)       winner_nxt = 2'b01;
    else if (score_b > score_a)       winner_nxt = 2'b10;
    else                              winner_nxt = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pa          <= '0;
      pb          <= '0;
      last_points <= '0;
      round_cnt   <= '0;
      score_a     <= '0;
      score_b     <= '0;
      wins_a      <= '0;
      wins_b      <= '0;
      winner      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pa          <= '0;
            pb          <= '0;
            last_points <= '0;
            round_cnt   <= '0;
            score_a     <= '0;
            score_b     <= '0;
            wins_a      <= '0;
            wins_b      <= '0;
            winner      <= '0;
          end
        end
        S_WAIT_A: begin
          if (accept) begin
            last_points <= points;
            pa          <= points;
            score_a     <= sat_add(score_a, points);
          end
        end
        S_WAIT_B: begin
          if (accept) begin
            last_points <= points;
            pb          <= points;
            score_b     <= sat_add(score_b, points);
          end
        end
        S_EVAL: begin
          wins_a    <= wins_a_nxt;
          wins_b    <= wins_b_nxt;
          round_cnt <= round_cnt_inc;
          if (last_round) winner <= winner_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dart_match.sv
// Directed bench for dart_match (COORD_W=2, ROUNDS=3, SCORE_W=3): table of rounds plus
// hand-written handshake, ignored-input and asynchronous reset sequences.
module tb_dart_match;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       throw_valid;
  logic [1:0] throw_x, throw_y;
  logic       throw_ready, turn;
  logic [2:0] last_points;
  logic [1:0] round_cnt, wins_a, wins_b;
  logic [2:0] score_a, score_b;
  logic       round_valid, done;
  logic [1:0] round_result, winner;

  int total = 0;
  int bad   = 0;

  dart_match #(.COORD_W(2), .ROUNDS(3), .SCORE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .throw_valid(throw_valid),
    .throw_x(throw_x), .throw_y(throw_y), .throw_ready(throw_ready), .turn(turn),
    .last_points(last_points), .round_cnt(round_cnt), .score_a(score_a),
    .score_b(score_b), .wins_a(wins_a), .wins_b(wins_b), .round_valid(round_valid),
    .round_result(round_result), .done(done), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ax, ay, bx, by;
    int pa, pb, res, wa, wb, sa, sb, win;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, throw_ready, 0);
    chk({tag, "_turn"}, turn, 0);
    chk({tag, "_lastpts"}, last_points, 0);
    chk({tag, "_rcnt"}, round_cnt, 0);
    chk({tag, "_score_a"}, score_a, 0);
    chk({tag, "_score_b"}, score_b, 0);
    chk({tag, "_wins"}, {wins_a, wins_b}, 0);
    chk({tag, "_rvalid"}, round_valid, 0);
    chk({tag, "_result"}, round_result, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_winner"}, winner, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        ax ay bx by  pa pb res wa wb sa sb win
    vecs[0]  = '{0, 0, 1, 2, 3, 1, 1, 1, 0, 3, 1, 0};
    vecs[1]  = '{3, 0, 0, 1, 0, 2, 2, 1, 1, 3, 3, 0};
    vecs[2]  = '{1, 1, 1, 1, 2, 2, 3, 1, 1, 5, 5, 3};
    vecs[3]  = '{0, 0, 2, 2, 3, 1, 1, 1, 0, 3, 1, 0};
    vecs[4]  = '{0, 1, 3, 3, 2, 0, 1, 2, 0, 5, 1, 0};
    vecs[5]  = '{3, 3, 0, 0, 0, 3, 2, 2, 1, 5, 4, 1};
    vecs[6]  = '{0, 0, 3, 3, 3, 0, 1, 1, 0, 3, 0, 0};
    vecs[7]  = '{2, 2, 1, 1, 1, 2, 2, 1, 1, 4, 2, 0};
    vecs[8]  = '{1, 1, 1, 1, 2, 2, 3, 1, 1, 6, 4, 1};
    vecs[9]  = '{3, 3, 0, 0, 0, 3, 2, 0, 1, 0, 3, 0};
    vecs[10] = '{1, 1, 2, 2, 2, 1, 1, 1, 1, 2, 4, 0};
    vecs[11] = '{1, 1, 1, 1, 2, 2, 3, 1, 1, 4, 6, 2};
    vecs[12] = '{0, 0, 3, 3, 3, 0, 1, 1, 0, 3, 0, 0};
    vecs[13] = '{0, 0, 3, 3, 3, 0, 1, 2, 0, 6, 0, 0};
    vecs[14] = '{0, 0, 3, 3, 3, 0, 1, 3, 0, 7, 0, 1};

    start = 1'b0; throw_valid = 1'b0; throw_x = '0; throw_y = '0;
    do_reset();
    chk_all_zero("reset");

    // Throws in IDLE without start are ignored.
    throw_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("idle_throw");

    // start together with throw_valid: only the start happens.
    throw_x = 2'd0; throw_y = 2'd0;
    do_start();
    throw_valid = 1'b0;
    chk("start_ready", throw_ready, 1);
    chk("start_lastpts", last_points, 0);
    chk("start_score_a", score_a, 0);

    // start in WAIT_A ignored, then A throws, then start in WAIT_B ignored.
    do_start();
    chk("ign_start_a_ready", throw_ready, 1);
    chk("ign_start_a_turn", turn, 0);
    throw_valid = 1'b1; throw_x = 2'd1; throw_y = 2'd0;
    @(negedge clk);
    throw_valid = 1'b0;
    chk("wb_turn", turn, 1);
    chk("wb_score_a", score_a, 2);
    do_start();
    chk("ign_start_b_turn", turn, 1);
    chk("ign_start_b_score_a", score_a, 2);

    // Asynchronous reset in WAIT_B, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Held valid with (0,0): A and B on consecutive edges; valid also held into EVAL.
    do_start();
    throw_valid = 1'b1; throw_x = 2'd0; throw_y = 2'd0;
    @(negedge clk);
    chk("held_a_pts", last_points, 3);
    chk("held_turn_b", turn, 1);
    @(negedge clk);
    throw_x = 2'd3; throw_y = 2'd3;
    chk("held_eval_rvalid", round_valid, 1);
    chk("held_eval_result", round_result, 3);
    chk("held_eval_ready", throw_ready, 0);
    chk("held_b_score", score_b, 3);
    @(negedge clk);
    throw_valid = 1'b0;
    chk("eval_ignored_pts", last_points, 3);
    chk("eval_ignored_score_b", score_b, 3);
    chk("held_rcnt", round_cnt, 1);
    chk("held_rvalid_low", round_valid, 0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      if (i % 3 == 0) begin
        do_start();
        chk($sformatf("v%0d_start_rcnt", i), round_cnt, 0);
        chk($sformatf("v%0d_start_scores", i), {score_a, score_b}, 0);
        chk($sformatf("v%0d_start_done", i), done, 0);
        chk($sformatf("v%0d_start_winner", i), winner, 0);
      end
      chk($sformatf("v%0d_ready_a", i), throw_ready, 1);
      chk($sformatf("v%0d_turn_a", i), turn, 0);
      throw_valid = 1'b1;
      throw_x = 2'(vecs[i].ax); throw_y = 2'(vecs[i].ay);
      @(negedge clk);
      chk($sformatf("v%0d_pts_a", i), last_points, vecs[i].pa);
      chk($sformatf("v%0d_score_a", i), score_a, vecs[i].sa);
      chk($sformatf("v%0d_turn_b", i), turn, 1);
      throw_x = 2'(vecs[i].bx); throw_y = 2'(vecs[i].by);
      @(negedge clk);
      throw_valid = 1'b0;
      chk($sformatf("v%0d_rvalid", i), round_valid, 1);
      chk($sformatf("v%0d_result", i), round_result, vecs[i].res);
      chk($sformatf("v%0d_pts_b", i), last_points, vecs[i].pb);
      chk($sformatf("v%0d_score_b", i), score_b, vecs[i].sb);
      chk($sformatf("v%0d_eval_done", i), done, 0);
      @(negedge clk);
      chk($sformatf("v%0d_rvalid_low", i), round_valid, 0);
      chk($sformatf("v%0d_wins_a", i), wins_a, vecs[i].wa);
      chk($sformatf("v%0d_wins_b", i), wins_b, vecs[i].wb);
      chk($sformatf("v%0d_rcnt", i), round_cnt, (i % 3) + 1);
      chk($sformatf("v%0d_done", i), done, (i % 3 == 2) ? 1 : 0);
      chk($sformatf("v%0d_winner", i), winner, vecs[i].win);
      chk($sformatf("v%0d_ready_after", i), throw_ready, (i % 3 == 2) ? 0 : 1);
    end

    // DONE holds its results and ignores throws.
    throw_valid = 1'b1; throw_x = 2'd0; throw_y = 2'd0;
    repeat (2) @(negedge clk);
    throw_valid = 1'b0;
    chk("done_hold_score_a", score_a, 7);
    chk("done_hold_winner", winner, 1);
    chk("done_hold_done", done, 1);
    chk("done_hold_pts", last_points, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
